// File: rtl/pes_farm_sensor.sv
// Farm-road vehicle detector: synchronises and debounces the loop input, counts waiting
// vehicles and drives the sensor request into pes_traffic with a post-green hold-off.
module pes_farm_sensor #(
  parameter int DEB_CYCLES     = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int QW             = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          raw_loop,
  input  logic [2:0]    light_farm,
  output logic          sensor,
  output logic [QW-1:0] queue_cnt,
  output logic          light_err
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [QW-1:0] Q_MAX     = '1;

  typedef enum logic [1:0] {IDLE, REQUEST, SERVING, HOLDOFF} state_t;

  logic          s1, s2, deb, deb_d;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [QW-1:0] q_next;
  state_t        state, state_next;
  logic          is_green, one_hot, arrival, departure;

  always_comb begin
    one_hot = 1'b0;
    case (light_farm)
      3'b100, 3'b010, 3'b001: one_hot = 1'b1;
      default:                one_hot = 1'b0;
    endcase
  end

  // Non-one-hot codes never compare equal to GREEN, so they are treated as not GREEN.
  assign is_green  = (light_farm == 3'b001);
  // Edges of the debounced level are acted on one cycle after the level changes.
  assign arrival   = deb & ~deb_d;
  assign departure = ~deb & deb_d & is_green;

  always_comb begin
    q_next = queue_cnt;
    if (arrival && queue_cnt != Q_MAX)
      q_next = queue_cnt + QW'(1);
    else if (departure && queue_cnt != '0)
      q_next = queue_cnt - QW'(1);
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE:    if (q_next != '0) state_next = REQUEST;
      REQUEST: if (is_green) state_next = SERVING;
      SERVING: begin
        if (!is_green || q_next == '0) begin
          state_next = HOLDOFF;
          hold_next  = HOLD_LAST;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == '0)
          state_next = (q_next != '0) ? REQUEST : IDLE;
        else
          hold_next = hold_cnt - HW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      deb       <= 1'b0;
      deb_d     <= 1'b0;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      queue_cnt <= '0;
      state     <= IDLE;
      sensor    <= 1'b0;
      light_err <= 1'b0;
    end else begin
      s1    <= raw_loop;
      s2    <= s1;
      deb_d <= deb;
      if (s2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      queue_cnt <= q_next;
      state     <= state_next;
      hold_cnt  <= hold_next;
      sensor    <= (state_next == REQUEST) || (state_next == SERVING);
      if (!one_hot) light_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pes_farm_sensor.sv
// Bench for pes_farm_sensor: directed scenarios plus random loop/light traffic checked
// against a behavioural model built from window-based debounce and per-phase rules.
module tb_pes_farm_sensor;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int QW   = 4;
  localparam int QMAX = (1 << QW) - 1;
  localparam int P_IDLE = 0, P_REQ = 1, P_SRV = 2, P_HOLD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          raw_loop = 1'b0;
  logic [2:0]    light_farm = 3'b100;
  logic          sensor;
  logic [QW-1:0] queue_cnt;
  logic          light_err;

  int checks = 0;
  int errors = 0;

  // model state: raw history per edge (index 0 = newest), debounced level, pending event
  bit rh[DEB+2];
  bit m_deb, m_err, m_sensor;
  int m_pend, m_cnt, m_phase, m_hold;

  pes_farm_sensor #(.DEB_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD), .QW(QW)) dut (
    .clk(clk), .rst_n(rst_n), .raw_loop(raw_loop), .light_farm(light_farm),
    .sensor(sensor), .queue_cnt(queue_cnt), .light_err(light_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    foreach (rh[j]) rh[j] = 1'b0;
    m_deb = 0; m_err = 0; m_sensor = 0;
    m_pend = 0; m_cnt = 0; m_phase = P_IDLE; m_hold = 0;
  endfunction

  function automatic void model_step();
    int ev;
    bit flip, green;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = m_pend;
    for (int j = DEB + 1; j > 0; j--) rh[j] = rh[j-1];
    rh[0] = raw_loop;
    // synced sample seen at this edge is the raw value two edges back
    flip = 1;
    for (int j = 2; j <= DEB + 1; j++) if (rh[j] == m_deb) flip = 0;
    m_pend = 0;
    if (flip) begin
      m_deb  = !m_deb;
      m_pend = m_deb ? 1 : -1;
    end
    green = (light_farm == 3'b001);
    if (ev == 1 && m_cnt < QMAX) m_cnt++;
    else if (ev == -1 && green && m_cnt > 0) m_cnt--;
    if (!(light_farm == 3'b100 || light_farm == 3'b010 || light_farm == 3'b001)) m_err = 1;
    case (m_phase)
      P_IDLE: if (m_cnt != 0) m_phase = P_REQ;
      P_REQ:  if (green) m_phase = P_SRV;
      P_SRV:  if (!green || m_cnt == 0) begin m_phase = P_HOLD; m_hold = HOLD; end
      default: begin
        m_hold--;
        if (m_hold == 0) m_phase = (m_cnt != 0) ? P_REQ : P_IDLE;
      end
    endcase
    m_sensor = (m_phase == P_REQ) || (m_phase == P_SRV);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    raw_loop = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({sensor, queue_cnt, light_err} !== '0) begin
        errors++;
        $display("FAIL reset cyc %0d got s=%b q=%0d e=%b want all 0", i, sensor, queue_cnt, light_err);
      end
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_short_pulse();
    light_farm = 3'b100;
    raw_loop = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) raw_loop = 1'b0;
      tick();
      checks++;
      if (sensor !== 1'b0 || queue_cnt !== '0 || m_cnt != 0) begin
        errors++;
        $display("FAIL short_pulse cyc %0d got s=%b q=%0d want s=0 q=0", i, sensor, queue_cnt);
      end
    end
    $display("test_short_pulse done");
  endtask

  task automatic test_latency();
    do_reset();
    light_farm = 3'b100;
    tick();
    raw_loop = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (sensor !== (e >= 7) || queue_cnt !== QW'(e >= 7 ? 1 : 0)) begin
        errors++;
        $display("FAIL latency edge %0d got s=%b q=%0d want s=%b q=%0d", e, sensor, queue_cnt,
                 e >= 7, e >= 7 ? 1 : 0);
      end
    end
    // two further 20-cycle vehicles under RED, gap 20
    for (int k = 0; k < 100; k++) begin
      raw_loop = ((k % 40) >= 20) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if ({sensor, queue_cnt, light_err} !== {m_sensor, QW'(m_cnt), m_err}) begin
        errors++;
        $display("FAIL latency_model cyc %0d got s=%b q=%0d want s=%b q=%0d", k, sensor, queue_cnt,
                 m_sensor, m_cnt);
      end
    end
    checks++;
    if (queue_cnt !== QW'(3) || sensor !== 1'b1) begin
      errors++;
      $display("FAIL three_cars got q=%0d s=%b want q=3 s=1", queue_cnt, sensor);
    end
    $display("test_latency done q=%0d", queue_cnt);
  endtask

  task automatic test_serve_to_zero();
    int lows;
    do_reset();
    light_farm = 3'b100;
    raw_loop = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    light_farm = 3'b001;
    for (int i = 0; i < 3; i++) tick();
    raw_loop = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    checks++;
    if (queue_cnt !== '0 || sensor !== 1'b0) begin
      errors++;
      $display("FAIL depart_to_zero got q=%0d s=%b want q=0 s=0", queue_cnt, sensor);
    end
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sensor == 1'b0) lows++;
      checks++;
      if ({sensor, queue_cnt} !== {m_sensor, QW'(m_cnt)}) begin
        errors++;
        $display("FAIL serve_model cyc %0d got s=%b q=%0d want s=%b q=%0d", i, sensor, queue_cnt,
                 m_sensor, m_cnt);
      end
    end
    checks++;
    if (lows != 20) begin
      errors++;
      $display("FAIL idle_after_zero got %0d low cycles want 20", lows);
    end
    $display("test_serve_to_zero done");
  endtask

  task automatic test_holdoff();
    int lows;
    do_reset();
    light_farm = 3'b100;
    raw_loop = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    raw_loop = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    raw_loop = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    light_farm = 3'b001;
    for (int i = 0; i < 4; i++) tick();
    raw_loop = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (queue_cnt !== QW'(1) || sensor !== 1'b1) begin
      errors++;
      $display("FAIL one_departure got q=%0d s=%b want q=1 s=1", queue_cnt, sensor);
    end
    light_farm = 3'b010;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if ({sensor, queue_cnt} !== {m_sensor, QW'(m_cnt)}) begin
        errors++;
        $display("FAIL holdoff_model cyc %0d got s=%b q=%0d want s=%b q=%0d", i, sensor, queue_cnt,
                 m_sensor, m_cnt);
      end
      if (sensor == 1'b1) break;
      lows++;
    end
    checks++;
    if (lows != HOLD || queue_cnt !== QW'(1)) begin
      errors++;
      $display("FAIL holdoff_len got %0d low q=%0d want %0d low q=1", lows, queue_cnt, HOLD);
    end
    $display("test_holdoff done lows=%0d", lows);
  endtask

  task automatic test_saturate_err();
    do_reset();
    light_farm = 3'b100;
    for (int k = 0; k < 17 * 12; k++) begin
      raw_loop = ((k % 12) < 6) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if ({sensor, queue_cnt, light_err} !== {m_sensor, QW'(m_cnt), m_err}) begin
        errors++;
        $display("FAIL sat_model cyc %0d got q=%0d want q=%0d", k, queue_cnt, m_cnt);
      end
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (queue_cnt !== QW'(QMAX)) begin
      errors++;
      $display("FAIL saturate got q=%0d want %0d", queue_cnt, QMAX);
    end
    light_farm = 3'b011;
    tick();
    light_farm = 3'b100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (light_err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky cyc %0d got e=%b want 1", i, light_err);
      end
    end
    raw_loop = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({sensor, queue_cnt, light_err} !== '0) begin
      errors++;
      $display("FAIL async_reset got s=%b q=%0d e=%b want all 0", sensor, queue_cnt, light_err);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (queue_cnt !== QW'(1) || light_err !== 1'b0 || sensor !== 1'b1) begin
      errors++;
      $display("FAIL recount got q=%0d e=%b s=%b want q=1 e=0 s=1", queue_cnt, light_err, sensor);
    end
    raw_loop = 1'b0;
    $display("test_saturate_err done");
  endtask

  task automatic test_random();
    int run_raw = 0, run_lf = 0, sel;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (run_raw == 0) begin
        raw_loop = 1'($urandom_range(1, 0));
        run_raw = $urandom_range(12, 1);
      end
      if (run_lf == 0) begin
        sel = $urandom_range(99, 0);
        light_farm = (sel < 40) ? 3'b100 : (sel < 55) ? 3'b010 : (sel < 99) ? 3'b001 : 3'b110;
        run_lf = $urandom_range(40, 5);
      end
      run_raw--;
      run_lf--;
      tick();
      checks++;
      if ({sensor, queue_cnt, light_err} !== {m_sensor, QW'(m_cnt), m_err}) begin
        errors++;
        $display("FAIL random cyc %0d got s=%b q=%0d e=%b want s=%b q=%0d e=%b", i, sensor,
                 queue_cnt, light_err, m_sensor, m_cnt, m_err);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_latency();
    test_serve_to_zero();
    test_holdoff();
    test_saturate_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
